// File: rtl/exc_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : exc_irq_ctrl
// Brief   : Prioritising exception/interrupt controller with pending latch,
//           EStatus capture, one-cycle line acknowledge and handler tracking.
// Revision: 1.0 - initial release
// ============================================================================
module exc_irq_ctrl #(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 invalid_op,
  input  logic                 eret_in,
  input  logic                 exc_ack,
  input  logic [N_IRQ-1:0]     ext_irq,
  input  logic [N_IRQ-1:0]     irq_mask,
  output logic                 exc,
  output logic [ESTATUS_W-1:0] estatus,
  output logic [N_IRQ-1:0]     ext_iack,
  output logic                 in_handler,
  output logic                 double_fault
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [ESTATUS_W-1:0] C_SYNC_CAUSE = {{(ESTATUS_W-1){1'b0}}, 1'b1};
  localparam logic [ESTATUS_W-1:0] C_IRQ_BASE   = {1'b1, {(ESTATUS_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_HANDLER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_IRQ-1:0]     pend_q, pend_d;
  logic [ESTATUS_W-1:0] estatus_q, estatus_d;
  logic [N_IRQ-1:0]     iack_q, iack_d;
  logic                 exc_q, exc_d;
  logic                 in_handler_q, in_handler_d;
  logic                 df_q, df_d;
  logic                 src_irq_q, src_irq_d;
  logic [IDX_W-1:0]     src_idx_q, src_idx_d;

  logic [N_IRQ-1:0]     w_req;
  logic                 w_any_req;
  logic [IDX_W-1:0]     w_req_idx;

  // Requests arriving this cycle are arbitrated together with latched ones,
  // giving a single-cycle latency from the request edge to exc.
  always_comb begin
    w_req     = (pend_q | ext_irq) & irq_mask;
    w_any_req = |w_req;
    w_req_idx = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (w_req[k]) w_req_idx = IDX_W'(k);
    end
  end

  always_comb begin
    state_d   = state_q;
    estatus_d = estatus_q;
    src_irq_d = src_irq_q;
    src_idx_d = src_idx_q;
    df_d      = df_q;
    iack_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (invalid_op) begin
          state_d   = S_PENDING;
          estatus_d = C_SYNC_CAUSE;
          src_irq_d = 1'b0;
        end else if (w_any_req) begin
          state_d   = S_PENDING;
          estatus_d = C_IRQ_BASE | {{(ESTATUS_W-IDX_W){1'b0}}, w_req_idx};
          src_irq_d = 1'b1;
          src_idx_d = w_req_idx;
        end
      end
      S_PENDING: begin
        if (exc_ack) begin
          state_d = S_HANDLER;
          if (src_irq_q) begin
            for (int k = 0; k < N_IRQ; k++) begin
              iack_d[k] = (IDX_W'(k) == src_idx_q);
            end
          end
        end
      end
      S_HANDLER: begin
        if (eret_in) begin
          state_d = S_IDLE;
        end else if (invalid_op) begin
          df_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear at the acknowledging edge and through the ack cycle; clear wins.
    pend_d       = (pend_q | (ext_irq & irq_mask)) & ~(iack_d | iack_q);
    exc_d        = (state_d == S_PENDING);
    in_handler_d = (state_d == S_HANDLER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      estatus_q    <= '0;
      iack_q       <= '0;
      exc_q        <= 1'b0;
      in_handler_q <= 1'b0;
      df_q         <= 1'b0;
      src_irq_q    <= 1'b0;
      src_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      estatus_q    <= estatus_d;
      iack_q       <= iack_d;
      exc_q        <= exc_d;
      in_handler_q <= in_handler_d;
      df_q         <= df_d;
      src_irq_q    <= src_irq_d;
      src_idx_q    <= src_idx_d;
    end
  end

  assign exc          = exc_q;
  assign estatus      = estatus_q;
  assign ext_iack     = iack_q;
  assign in_handler   = in_handler_q;
  assign double_fault = df_q;

endmodule
`default_nettype wire

// File: doc/exc_irq_ctrl.md
Name: exc_irq_ctrl

Overview:
- Sequential exception/interrupt controller; generalises the single-line ExtIRQ/ExcAck logic of the LEGv8 processor controller.
- Accepts N_IRQ maskable external interrupt lines plus the decoder's invalid-opcode flag.
- Prioritises requests, drives the exception request to the datapath and captures EStatus.
- Returns one-cycle acknowledges to peripherals and tracks handler state until ERET.

Parameters:
- N_IRQ, 4, number of external interrupt lines; legal 1..2^(ESTATUS_W-1).
- ESTATUS_W, 4, width of EStatus; ≥2.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- invalid_op  in  1  main decoder flags current instruction as unimplemented
- eret_in  in  1  main decoder flags current instruction as ERET
- exc_ack  in  1  datapath has redirected PC to exception vector
- ext_irq  in  N_IRQ  level interrupt requests, bit k = line k
- irq_mask  in  N_IRQ  1 = line enabled
- exc  out  1  exception request to datapath (PC-select/ELR write)
- estatus  out  ESTATUS_W  cause of the exception being/last serviced
- ext_iack  out  N_IRQ  one-hot, one-cycle acknowledge to the serviced line
- in_handler  out  1  controller is in handler state
- double_fault  out  1  sticky: invalid opcode while already in handler

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- All outputs registered. Reset values: exc=0, estatus=0, ext_iack=0, in_handler=0, double_fault=0, pending=0, state=IDLE.
- Pending register pend[N_IRQ-1:0], updated every cycle in every state.
  - pend[k] <= (pend[k] | (ext_irq[k] & irq_mask[k])) & ~clr[k].
  - clr[k] is high in the cycle ext_iack[k] is driven; clear wins over set.
  - A line still high the cycle after its ack re-pends.
  - Masking a line does not clear an already-set pend bit; it hides it from arbitration.
- Cause encoding:
  - invalid opcode = 1.
  - IRQ k = 2^(ESTATUS_W-1) + k.
- Priority: invalid_op > enabled pending line with lowest index. Arbitration considers pend & irq_mask.
- States:
  - IDLE: in_handler=0, exc=0.
    - invalid_op=1 -> PENDING, estatus<=1, src<=SYNC.
    - else any (pend & irq_mask) -> PENDING, estatus<=IRQ code, src<=k.
    - exc rises the cycle after the triggering edge (latency 1).
  - PENDING: exc=1 held until exc_ack.
    - New requests do not preempt or change estatus.
    - exc_ack=1 -> HANDLER. In the same edge, if src is IRQ k: ext_iack[k]=1 for exactly the next cycle and pend[k] cleared.
    - invalid_op and eret_in are ignored in this state.
  - HANDLER: in_handler=1, exc=0; no nesting.
    - eret_in=1 -> IDLE. Pending requests are arbitrated from IDLE on the following edge, so the minimum gap between ERET and the next exc is 2 cycles.
    - invalid_op=1 without eret_in -> double_fault<=1; state and estatus unchanged.
    - eret_in and invalid_op in the same cycle -> ERET wins, no double fault.
- Other input cases:
  - eret_in in IDLE: ignored.
  - exc_ack outside PENDING: ignored.
- estatus holds its value through HANDLER and after return until the next capture.
- double_fault cleared only by reset.
- Reset mid-operation (any state) returns everything to reset values next edge; in-flight pend bits are lost and no ack is issued.

Test Plan:
- Reset then idle: reset=1 two cycles, all inputs 0 -> exc=0, estatus=0, ext_iack=0, in_handler=0, double_fault=0.
- Single IRQ: irq_mask=4'b1111, ext_irq[2] pulsed one cycle at t.
  - exc=1 at t+1, estatus=4'b1010 (defaults N_IRQ=4, ESTATUS_W=4).
  - exc_ack at t+3 -> ext_iack=4'b0100 for one cycle at t+4, in_handler=1, pend[2]=0.
  - eret_in at t+6 -> in_handler=0 at t+7.
- Priority: ext_irq=4'b1010 and invalid_op=1 in the same cycle, mask=4'b1111.
  - First service has estatus=1 and no iack.
  - After ERET, the next service has estatus=4'b1001 with iack=4'b0010.
  - Then the next has estatus=4'b1011 with iack=4'b1000.
- Masking: ext_irq[0]=1, mask=4'b1110 -> exc stays 0. Set mask=4'b1111 -> exc=1 next cycle, estatus=4'b1000.
- Double fault: in HANDLER, invalid_op=1 -> double_fault=1 next cycle, estatus unchanged, no exc. Same cycle with eret_in=1 (fresh reset) -> double_fault stays 0.
- Reset mid-PENDING: exc=1, pend=4'b0110, reset=1 -> next cycle all outputs 0, pend=0. No ext_iack pulse even if exc_ack=1 the same cycle.
